// File: rtl/mul_hash_window_if.sv
// Byte-stream sideband, multiplier partial products and hash outputs of mul_hash_window.
// master = producer side (multiplier/stream driver), slave = the hasher itself.
interface mul_hash_window_if #(
    parameter int HASH_W = 16
);
    logic              s_valid;
    logic              s_last;
    logic [23:0]       ab0;
    logic [23:0]       ab1;
    logic [23:0]       ab2;
    logic [23:0]       ab3;
    logic              h_valid;
    logic              h_last;
    logic [HASH_W-1:0] h_hash;
    logic [63:0]       h_prod;

    modport master (
        output s_valid, s_last, ab0, ab1, ab2, ab3,
        input  h_valid, h_last, h_hash, h_prod
    );

    modport slave (
        input  s_valid, s_last, ab0, ab1, ab2, ab3,
        output h_valid, h_last, h_hash, h_prod
    );
endinterface

// File: rtl/mul_hash_window.sv
// Rebuilds P = a*B mod 2^64 from four partial products and folds the last NGRAM products
// into a sliding-window hash. Optional macro MUL_HASH_WIN_PROD_OUT_EN exposes newest P on h_prod.
module mul_hash_window #(
    parameter int MUL_LAT = 5,
    parameter int NGRAM   = 4,
    parameter int HASH_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    mul_hash_window_if.slave bus
);
    localparam int FILL_W = $clog2(NGRAM + 1);
`ifdef MUL_HASH_WIN_PROD_OUT_EN
    localparam int P_LO   = 0;
`else
    // Lowest product bit any rotated window term can move into the hash slice.
    localparam int RAW_LO = 64 - HASH_W - 8 * (NGRAM - 1);
    localparam int P_LO   = (RAW_LO > 0) ? RAW_LO : 0;
`endif
    localparam int P_W    = 64 - P_LO;

    function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_W'(NGRAM)) ? f : f + 1'b1;
    endfunction

    function automatic logic [63:0] widen(input logic [P_W-1:0] w);
        logic [63:0] x;
        x = '0;
        x[63:P_LO] = w;
        return x;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned sh);
        return (sh == 0) ? x : ((x << sh) | (x >> (64 - sh)));
    endfunction

    logic [MUL_LAT-1:0] vld_dl;
    logic [MUL_LAT-1:0] last_dl;
    logic [71:0]        prod_full;
    logic               prod_unused;
    logic               vld_p0;
    logic               last_p0;
    logic [P_W-1:0]     prod_p0;
    logic [P_W-1:0]     win      [NGRAM];
    logic [P_W-1:0]     win_next [NGRAM];
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_inc;
    logic [63:0]        hash_full;
    logic               hash_unused;
    logic [HASH_W-1:0]  hash_next;
    logic               emit;
    logic               vld_p1;
    logic               last_p1;
    logic [HASH_W-1:0]  hash_p1;

    // ---- sideband delay line, aligned with ab0..ab3 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_dl  <= '0;
            last_dl <= '0;
        end else begin
            vld_dl[0]  <= bus.s_valid;
            last_dl[0] <= bus.s_valid & bus.s_last;
            for (int k = 1; k < MUL_LAT; k++) begin
                vld_dl[k]  <= vld_dl[k-1];
                last_dl[k] <= last_dl[k-1];
            end
        end
    end

    // ---- stage R: product reconstruction ----
    always_comb begin
        prod_full = 72'(bus.ab0)
                  + (72'(bus.ab1) << 16)
                  + (72'(bus.ab2) << 32)
                  + (72'(bus.ab3) << 48);
    end
    assign prod_unused = ^prod_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= vld_dl[MUL_LAT-1];
            last_p0 <= last_dl[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        prod_p0 <= prod_full[63:P_LO];
    end

    // ---- stage W: window shift, fill count and hash fold ----
    always_comb begin
        win_next[0] = prod_p0;
        for (int k = 1; k < NGRAM; k++) win_next[k] = win[k-1];
        hash_full = '0;
        for (int k = 0; k < NGRAM; k++) hash_full ^= rotl(widen(win_next[k]), 8 * k);
    end
    assign hash_next   = hash_full[63 -: HASH_W];
    assign hash_unused = ^hash_full;
    assign fill_inc    = sat_inc(fill);
    assign emit        = vld_p0 && (fill_inc == FILL_W'(NGRAM));

    always_ff @(posedge clk) begin
        if (rst) begin
            fill    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= emit;
            last_p1 <= emit & last_p0;
            if (vld_p0) fill <= last_p0 ? '0 : fill_inc;
        end
    end

    // A packet's last byte is hashed first, then the window is emptied for the next packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NGRAM; k++) win[k] <= '0;
            hash_p1 <= '0;
        end else begin
            if (vld_p0) begin
                for (int k = 0; k < NGRAM; k++) win[k] <= last_p0 ? '0 : win_next[k];
            end
            if (emit) hash_p1 <= hash_next;
        end
    end

`ifdef MUL_HASH_WIN_PROD_OUT_EN
    logic [63:0] prod_p1;

    always_ff @(posedge clk) begin
        if (rst) prod_p1 <= '0;
        else if (emit) prod_p1 <= widen(win_next[0]);
    end
    assign bus.h_prod = prod_p1;
`else
    assign bus.h_prod = '0;
`endif

    assign bus.h_valid = vld_p1;
    assign bus.h_last  = last_p1;
    assign bus.h_hash  = hash_p1;
endmodule

// File: tb/tb_mul_hash_window.sv
// Directed bench for mul_hash_window with an exact multiplier model feeding ab0..ab3.
// Honours MUL_HASH_WIN_PROD_OUT_EN for the h_prod expectations.
module tb_mul_hash_window;
    localparam int MUL_LAT = 5;
    localparam int NGRAM   = 4;
    localparam int HASH_W  = 16;
    localparam int LAT     = MUL_LAT + 2;
    localparam logic [63:0] B  = 64'h0b4e0ef37bc32127;
    localparam logic [63:0] B2 = 64'h169c1de6f786424e;
    localparam logic [15:0] B_0 = 16'h2127;
    localparam logic [15:0] B_1 = 16'h7bc3;
    localparam logic [15:0] B_2 = 16'h0ef3;
    localparam logic [15:0] B_3 = 16'h0b4e;

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        exp_v;
        logic        exp_l;
        logic [15:0] exp_h;
        logic [63:0] exp_p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_dat = 8'h00;
    logic [7:0]  mul_q [MUL_LAT];
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs [$];
    vec_t        e;
    logic [15:0] held_h;
    logic [63:0] held_p;
    int          nv, vcyc, first_c, last_c;
    logic [15:0] vh;
    logic        vl;
    logic [63:0] mwin [NGRAM];
    int          mfill;
    logic [63:0] acc;
    logic [15:0] exp_q [$];
    logic [15:0] exp_h;

    mul_hash_window_if #(.HASH_W(HASH_W)) bus ();

    mul_hash_window #(
        .MUL_LAT(MUL_LAT),
        .NGRAM  (NGRAM),
        .HASH_W (HASH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: byte in, partial products out MUL_LAT cycles later.
    always @(posedge clk) begin
        mul_q[0] <= s_dat;
        for (int k = 1; k < MUL_LAT; k++) mul_q[k] <= mul_q[k-1];
    end
    assign bus.ab0 = 24'(mul_q[MUL_LAT-1]) * 24'(B_0);
    assign bus.ab1 = 24'(mul_q[MUL_LAT-1]) * 24'(B_1);
    assign bus.ab2 = 24'(mul_q[MUL_LAT-1]) * 24'(B_2);
    assign bus.ab3 = 24'(mul_q[MUL_LAT-1]) * 24'(B_3);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.s_valid = v;
        s_dat       = d;
        bus.s_last  = l;
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic ev, input logic [15:0] eh, input logic [63:0] ep);
        vec_t r;
        r.vld = v; r.dat = d; r.last = l;
        r.exp_v = ev; r.exp_l = ev & l; r.exp_h = eh; r.exp_p = ep;
        return r;
    endfunction

    function automatic logic [63:0] prod_exp(input logic [63:0] p);
`ifdef MUL_HASH_WIN_PROD_OUT_EN
        return p;
`else
        return 64'(p & 64'd0);
`endif
    endfunction

    function automatic logic [63:0] ref_rotl(input logic [63:0] x, input int sh);
        if (sh == 0) return x;
        return (x << sh) | (x >> (64 - sh));
    endfunction

    initial begin
        // order: byte 01 oldest -> rotl(B,24)
        vecs.push_back(mk(1, 8'h01, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 1, 1, 16'hf37b, 64'h0));
        // gaps between bytes must not change the result
        vecs.push_back(mk(1, 8'h01, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 1, 1, 16'hf37b, 64'h0));
        // short packet emits nothing, then a full packet with 2B newest
        vecs.push_back(mk(1, 8'h01, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h01, 1, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h02, 1, 1, 16'h169c, B2));
        // newest term unrotated
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 16'h0, 64'h0));
        vecs.push_back(mk(1, 8'h01, 1, 1, 16'h0b4e, B));

        drive(0, 8'h00, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_h_valid", 64'(bus.h_valid), 64'd0);
        check("rst_h_last",  64'(bus.h_last),  64'd0);
        check("rst_h_hash",  64'(bus.h_hash),  64'd0);
        check("rst_h_prod",  bus.h_prod,       64'd0);
        rst = 1'b0;

        held_h = 16'h0;
        held_p = 64'h0;
        for (int i = 0; i < vecs.size() + LAT; i++) begin
            @(posedge clk);
            #1;
            if (i >= LAT) begin
                e = vecs[i - LAT];
                if (e.exp_v) begin
                    held_h = e.exp_h;
                    held_p = prod_exp(e.exp_p);
                end
                check($sformatf("vec%0d_valid", i - LAT), 64'(bus.h_valid), 64'(e.exp_v));
                check($sformatf("vec%0d_last",  i - LAT), 64'(bus.h_last),  64'(e.exp_l));
                check($sformatf("vec%0d_hash",  i - LAT), 64'(bus.h_hash),  64'(held_h));
                check($sformatf("vec%0d_prod",  i - LAT), bus.h_prod,       held_p);
            end
            if (i < vecs.size()) drive(vecs[i].vld, vecs[i].dat, vecs[i].last);
            else drive(0, 8'h00, 0);
        end

        // Reset mid-stream: three bytes in flight, a byte during reset, then a fresh packet.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive(1, 8'(i + 1), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 8'h05, 0);
        @(posedge clk);
        #1;
        check("midrst_h_valid", 64'(bus.h_valid), 64'd0);
        check("midrst_h_last",  64'(bus.h_last),  64'd0);
        check("midrst_h_hash",  64'(bus.h_hash),  64'd0);
        check("midrst_h_prod",  bus.h_prod,       64'd0);
        rst = 1'b0;
        nv = 0; vcyc = -1; vh = 16'h0; vl = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) drive(1, (c == 3) ? 8'h01 : 8'h00, c == 3);
            else drive(0, 8'h00, 0);
            @(posedge clk);
            #1;
            if (bus.h_valid) begin
                nv++;
                vcyc = c;
                vh = bus.h_hash;
                vl = bus.h_last;
            end
        end
        check("postrst_count", 64'(nv), 64'd1);
        check("postrst_cycle", 64'(vcyc), 64'(3 + LAT - 1));
        check("postrst_hash",  64'(vh), 64'h0b4e);
        check("postrst_last",  64'(vl), 64'd1);
        check("postrst_prod",  bus.h_prod, prod_exp(B));

        // Streaming: 64 random back-to-back bytes against a direct a*B reference.
        for (int k = 0; k < NGRAM; k++) mwin[k] = 64'h0;
        mfill = 0; nv = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 64 + LAT + 4; c++) begin
            if (c < 64) begin
                drive(1, 8'($urandom_range(0, 255)), 0);
                for (int k = NGRAM - 1; k > 0; k--) mwin[k] = mwin[k-1];
                mwin[0] = 64'(s_dat) * B;
                if (mfill < NGRAM) mfill++;
                if (mfill == NGRAM) begin
                    acc = 64'h0;
                    for (int k = 0; k < NGRAM; k++) acc ^= ref_rotl(mwin[k], 8 * k);
                    exp_q.push_back(acc[63:48]);
                end
            end else begin
                drive(0, 8'h00, 0);
            end
            @(posedge clk);
            #1;
            if (bus.h_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_valid", 64'(bus.h_valid), 64'd0);
                end else begin
                    exp_h = exp_q.pop_front();
                    check($sformatf("stream%0d_hash", nv), 64'(bus.h_hash), 64'(exp_h));
                    check($sformatf("stream%0d_last", nv), 64'(bus.h_last), 64'd0);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nv++;
            end
        end
        check("stream_count",       64'(nv), 64'd61);
        check("stream_consecutive", 64'(last_c - first_c + 1), 64'(nv));
        check("stream_leftover",    64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
